musa_ctrl_checker: RTL and testbench

Synthesizable, runtime-programmable control-signal protocol checker for the MUSA core. Watches the fetched instruction and the decoder's control bundle, and for each of NUM_RULES programmable rules requires that every control bit in the rule's mask be high in at least one cycle of a [MIN_DLY:MAX_DLY] window after a matching opcode. Keeps per-rule pass/fail counters, a sticky fail vector and first-failure capture. It sits beside the core in both simulation and FPGA builds, so decode checking no longer depends on simulator assertions.

---
 rtl/musa_ctrl_checker.sv | 144 ++++++++++++++
 tb/tb_musa_ctrl_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/musa_ctrl_checker.sv
// Programmable control-bundle checker for the MUSA decoder: per-rule opcode trigger,
// windowed mask check, saturating pass/fail counters, sticky errors and first-failure capture.
module musa_ctrl_checker #(
    parameter int NUM_RULES  = 16,
    parameter int CTRL_WIDTH = 12,
    parameter int MIN_DLY    = 1,
    parameter int MAX_DLY    = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                  clk_musa,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  instr_valid,
    input  logic [31:0]           instruction,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [CTRL_WIDTH+7:0] cfg_wdata,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic [NUM_RULES-1:0]  err_pulse,
    output logic [NUM_RULES-1:0]  err_sticky,
    output logic                  fail_valid,
    output logic [IDX_W-1:0]      fail_rule,
    output logic [31:0]           fail_instr
);

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [CNT_WIDTH-1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    logic [NUM_RULES-1:0]  rule_en;
    logic [NUM_RULES-1:0]  rule_sel;
    logic [5:0]            rule_op   [NUM_RULES];
    logic [CTRL_WIDTH-1:0] rule_mask [NUM_RULES];
    logic [MAX_DLY:1]      pend      [NUM_RULES];
    logic [CNT_WIDTH-1:0]  pass_q    [NUM_RULES];
    logic [CNT_WIDTH-1:0]  fail_q    [NUM_RULES];
    logic [31:0]           instr_p   [1:MAX_DLY];

    logic [NUM_RULES-1:0]  trig;
    logic [NUM_RULES-1:0]  hit;
    logic [NUM_RULES-1:0]  fail_now;
    logic [CNT_WIDTH-1:0]  sat_num   [NUM_RULES];
    logic [MAX_DLY:1]      pend_nxt  [NUM_RULES];
    logic [5:0]            field;
    logic [IDX_W-1:0]      low_idx;

    // Stage p0: trigger match, hit evaluation and pending-window advance
    always_comb begin
        trig     = '0;
        hit      = '0;
        fail_now = '0;
        field    = '0;
        low_idx  = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            sat_num[r]  = '0;
            pend_nxt[r] = '0;
        end
        for (int r = 0; r < NUM_RULES; r++) begin
            field   = rule_sel[r] ? instruction[5:0] : instruction[31:26];
            trig[r] = instr_valid & rule_en[r] & (field == rule_op[r]);
            hit[r]  = (ctrl & rule_mask[r]) == rule_mask[r];
            // One hit satisfies every in-window attempt; each attempt is counted.
            for (int a = MIN_DLY; a <= MAX_DLY; a++)
                if (pend[r][a] && hit[r]) sat_num[r] = sat_num[r] + CNT_WIDTH'(1);
            fail_now[r]    = pend[r][MAX_DLY] & ~hit[r];
            pend_nxt[r][1] = trig[r];
            for (int a = 2; a <= MAX_DLY; a++)
                pend_nxt[r][a] = pend[r][a-1] & ~(hit[r] && (a - 1 >= MIN_DLY));
        end
        for (int r = NUM_RULES - 1; r >= 0; r--)
            if (fail_now[r]) low_idx = IDX_W'(r);
    end

    // Stage p1: configuration, pending state, counters and error capture
    always_ff @(posedge clk_musa or posedge rst) begin
        if (rst) begin
            rule_en    <= '0;
            rule_sel   <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
            fail_valid <= 1'b0;
            fail_rule  <= '0;
            fail_instr <= '0;
            for (int r = 0; r < NUM_RULES; r++) begin
                rule_op[r]   <= '0;
                rule_mask[r] <= '0;
                pend[r]      <= '0;
                pass_q[r]    <= '0;
                fail_q[r]    <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (cfg_we && cfg_idx == IDX_W'(r)) begin
                    rule_en[r]   <= cfg_wdata[CTRL_WIDTH+7];
                    rule_sel[r]  <= cfg_wdata[CTRL_WIDTH+6];
                    rule_op[r]   <= cfg_wdata[CTRL_WIDTH+5:CTRL_WIDTH];
                    rule_mask[r] <= cfg_wdata[CTRL_WIDTH-1:0];
                end
            end
            if (clear) begin
                err_pulse  <= '0;
                err_sticky <= '0;
                fail_valid <= 1'b0;
                fail_rule  <= '0;
                fail_instr <= '0;
                for (int r = 0; r < NUM_RULES; r++) begin
                    pend[r]   <= '0;
                    pass_q[r] <= '0;
                    fail_q[r] <= '0;
                end
            end else begin
                for (int r = 0; r < NUM_RULES; r++) begin
                    pend[r]   <= (cfg_we && cfg_idx == IDX_W'(r)) ? '0 : pend_nxt[r];
                    pass_q[r] <= sat_add(pass_q[r], sat_num[r]);
                    fail_q[r] <= sat_add(fail_q[r], CNT_WIDTH'(fail_now[r]));
                end
                err_pulse  <= fail_now;
                err_sticky <= err_sticky | fail_now;
                if (!fail_valid && |fail_now) begin
                    fail_valid <= 1'b1;
                    fail_rule  <= low_idx;
                    fail_instr <= instr_p[MAX_DLY];
                end
            end
        end
    end

    // Instruction delay line: word that triggered the entry now at age MAX_DLY
    always_ff @(posedge clk_musa) begin
        instr_p[1] <= instruction;
        for (int a = 2; a <= MAX_DLY; a++) instr_p[a] <= instr_p[a-1];
    end

    assign pass_cnt = pass_q[rd_idx];
    assign fail_cnt = fail_q[rd_idx];

endmodule

// File: tb/tb_musa_ctrl_checker.sv
// Scoreboard bench for musa_ctrl_checker: directed vectors push expected err_pulse events,
// a negedge monitor pops and compares them; state is checked inline after each scenario.
module tb_musa_ctrl_checker;

    logic        clk_musa = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [11:0] ctrl = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [19:0] cfg_wdata = '0;
    logic [3:0]  rd_idx = '0;
    logic [15:0] pass_cnt, fail_cnt, err_pulse, err_sticky;
    logic        fail_valid;
    logic [3:0]  fail_rule;
    logic [31:0] fail_instr;

    musa_ctrl_checker dut (
        .clk_musa(clk_musa), .rst(rst), .clear(clear), .instr_valid(instr_valid),
        .instruction(instruction), .ctrl(ctrl), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata), .rd_idx(rd_idx), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_pulse(err_pulse), .err_sticky(err_sticky), .fail_valid(fail_valid),
        .fail_rule(fail_rule), .fail_instr(fail_instr)
    );

    always #5 clk_musa = ~clk_musa;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] W0 = 32'hAC00_1234;
    localparam logic [31:0] W1 = 32'hAC00_5678;
    localparam logic [31:0] W3 = 32'h0000_0018;
    localparam logic [31:0] W4 = 32'h0400_0002;
    localparam logic [31:0] W5 = 32'h0C00_0000;
    localparam logic [31:0] W6 = 32'hFC00_0000;

    always @(posedge clk_musa) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_musa);
        #1;
    endtask

    task automatic cfg(input int idx, input logic en, input logic sel,
                       input logic [5:0] op, input logic [11:0] mask);
        cfg_we    = 1'b1;
        cfg_idx   = 4'(idx);
        cfg_wdata = {en, sel, op, mask};
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic trig(input logic [31:0] word);
        instr_valid = 1'b1;
        instruction = word;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic expect_err(input logic [15:0] val);
        exp_t e;
        e.cyc = cyc + 3;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk_cnt(input int idx, input logic [15:0] ep, input logic [15:0] ef);
        rd_idx = 4'(idx);
        #1;
        chk($sformatf("pass_cnt[%0d]", idx), {16'h0, pass_cnt}, {16'h0, ep});
        chk($sformatf("fail_cnt[%0d]", idx), {16'h0, fail_cnt}, {16'h0, ef});
    endtask

    task automatic chk_capture(input logic [15:0] st, input logic fv,
                               input logic [3:0] fr, input logic [31:0] fi);
        chk("err_sticky", {16'h0, err_sticky}, {16'h0, st});
        chk("fail_valid", {31'h0, fail_valid}, {31'h0, fv});
        chk("fail_rule", {28'h0, fail_rule}, {28'h0, fr});
        chk("fail_instr", fail_instr, fi);
    endtask

    // Monitor: every err_pulse must match the next expected event, value and cycle
    always @(negedge clk_musa) begin
        if (!rst && err_pulse != 16'h0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_err_pulse", {16'h0, err_pulse}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("err_pulse_val", {16'h0, err_pulse}, {16'h0, e.val});
                chk("err_pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("reset_err_pulse", {16'h0, err_pulse}, 32'h0);
        chk_capture(16'h0, 1'b0, 4'h0, 32'h0);
        chk_cnt(0, 16'h0, 16'h0);
        rst = 1'b0;
        step();

        // Rule 0 hit in the last window cycle
        cfg(0, 1'b1, 1'b0, 6'h2B, 12'h053);
        trig(W0);
        step();
        ctrl = 12'h053;
        step();
        ctrl = 12'h000;
        chk_cnt(0, 16'd1, 16'd0);

        // Rule 0 partial match in both window cycles fails
        expect_err(16'h0001);
        trig(W1);
        ctrl = 12'h013;
        step();
        step();
        ctrl = 12'h000;
        chk_cnt(0, 16'd1, 16'd1);
        chk_capture(16'h0001, 1'b1, 4'd0, W1);

        // Rule 3 overlapping attempts both satisfied by one hit
        cfg(3, 1'b1, 1'b1, 6'h18, 12'h00F);
        instr_valid = 1'b1;
        instruction = W3;
        step();
        step();
        instr_valid = 1'b0;
        ctrl = 12'h00F;
        step();
        ctrl = 12'h000;
        step();
        chk_cnt(3, 16'd2, 16'd0);

        // Config write in the trigger cycle drops that attempt
        cfg_we      = 1'b1;
        cfg_idx     = 4'd0;
        cfg_wdata   = {1'b1, 1'b0, 6'h2B, 12'h053};
        instr_valid = 1'b1;
        instruction = W0;
        step();
        cfg_we      = 1'b0;
        instr_valid = 1'b0;
        repeat (3) step();
        chk_cnt(0, 16'd1, 16'd1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_cnt(0, 16'd0, 16'd0);
        chk_cnt(3, 16'd0, 16'd0);
        chk_capture(16'h0, 1'b0, 4'h0, 32'h0);

        // Rules 2 and 5 fail together; lowest index captured
        cfg(2, 1'b1, 1'b0, 6'h01, 12'h100);
        cfg(5, 1'b1, 1'b1, 6'h02, 12'h400);
        expect_err(16'h0024);
        trig(W4);
        step();
        step();
        chk_capture(16'h0024, 1'b1, 4'd2, W4);
        chk_cnt(2, 16'd0, 16'd1);
        chk_cnt(5, 16'd0, 16'd1);

        // Later rule 1 failure leaves the capture alone
        cfg(1, 1'b1, 1'b0, 6'h03, 12'h800);
        expect_err(16'h0002);
        trig(W5);
        step();
        step();
        chk_capture(16'h0026, 1'b1, 4'd2, W4);
        chk_cnt(1, 16'd0, 16'd1);

        // Mask 0 rule: back-to-back passes, then saturation
        cfg(4, 1'b1, 1'b0, 6'h3F, 12'h000);
        instr_valid = 1'b1;
        instruction = W6;
        repeat (100) step();
        instr_valid = 1'b0;
        step();
        chk_cnt(4, 16'd100, 16'd0);
        instr_valid = 1'b1;
        repeat (65437) step();
        instr_valid = 1'b0;
        step();
        step();
        chk_cnt(4, 16'hFFFF, 16'd0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_cnt(4, 16'd0, 16'd0);
        chk_cnt(2, 16'd0, 16'd0);
        chk_capture(16'h0, 1'b0, 4'h0, 32'h0);

        // Configuration survives clear
        trig(W6);
        step();
        chk_cnt(4, 16'd1, 16'd0);
        trig(W0);
        step();
        ctrl = 12'h053;
        step();
        ctrl = 12'h000;
        chk_cnt(0, 16'd1, 16'd0);

        // Reset mid-window: no error, everything back to 0, rules disabled
        trig(W0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_err_pulse", {16'h0, err_pulse}, 32'h0);
        chk_capture(16'h0, 1'b0, 4'h0, 32'h0);
        chk_cnt(0, 16'd0, 16'd0);
        trig(W0);
        repeat (3) step();
        chk_cnt(0, 16'd0, 16'd0);
        chk("post_rst_err_sticky", {16'h0, err_sticky}, 32'h0);

        repeat (3) step();
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
